pose_inv: RTL
=============

Name: pose_inv

Overview:
- Inverts a rigid camera-to-world pose [R|t] into the world-to-camera pose [R^T | -R^T t].
- All elements are signed fixed-point, Q12.4 by default.
- Sits downstream of the c2w matrix multiply and feeds the w2c projection path.
- Uses one time-shared multiplier/accumulator and valid/ready handshakes on both sides.

Parameters:
TOTAL_BITS, 16, element width (signed two's complement)
FRAC_BITS, 4, fractional bits per element

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input pose valid
in_ready  out  1  block can accept a pose
r_in  in  9*TOTAL_BITS  R, element (i,j) at bits [(3*i+j)*TOTAL_BITS +: TOTAL_BITS]
t_in  in  3*TOTAL_BITS  t, element i at bits [i*TOTAL_BITS +: TOTAL_BITS]
out_valid  out  1  inverted pose valid
out_ready  in  1  consumer accepts the output
r_out  out  9*TOTAL_BITS  R^T, same packing as r_in
t_out  out  3*TOTAL_BITS  -(R^T t), same packing as t_in
ovf  out  1  some t_out element exceeded the TOTAL_BITS range in this transaction

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, r_out=0, t_out=0, ovf=0, accumulator=0, step counter=0.
- Reset mid-operation returns to IDLE and discards the partial result. No output is produced for the aborted pose.
- States: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (edge E0), latch r_in/t_in, load r_out with the transpose of r_in, clear acc/ovf, set k=0, go to MAC.
- MAC:
  - in_ready=0.
  - At edges E1..E9, step k=0..8 with i=k/3, j=k%3: acc += R[j][i]*t[j].
  - Each product is a full 2*TOTAL_BITS signed value; acc is 2*TOTAL_BITS+2 bits.
  - When j==2:
    - v = -(acc >>> FRAC_BITS), using an arithmetic shift (truncation toward -inf before negation).
    - Write v into t_out element i.
    - Set ovf if v lies outside [-2^(TOTAL_BITS-1), 2^(TOTAL_BITS-1)-1].
    - Clear acc.
  - After k=8, go to DONE.
- Latency: out_valid=1 after E9, i.e. 9 cycles after acceptance.
- DONE:
  - out_valid=1; r_out, t_out and ovf are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready stays 0 during the handshake cycle; no same-cycle bypass.
  - Next acceptance can occur one cycle later.
- in_valid during MAC/DONE is ignored. Upstream must hold its data until in_ready.
- Outputs keep their last values in IDLE until the next acceptance overwrites them.
- Throughput: at most one pose per 11 cycles.

Optional Feature:
- Macro POSE_INV_SAT_EN.
- Defined: out-of-range v saturates to 2^(TOTAL_BITS-1)-1 or -2^(TOTAL_BITS-1).
- Undefined: v wraps to its low TOTAL_BITS bits.
- ovf is flagged identically in both modes.

Test Plan:
- Identity R (diagonal raw 0x0010), t=(0x0010,0x0020,0x0030):
  - r_out = identity.
  - t_out = (0xFFF0,0xFFE0,0xFFD0), ovf=0.
  - out_valid rises exactly 9 cycles after acceptance.
- 90-degree z rotation R=[[0,0xFFF0,0],[0x0010,0,0],[0,0,0x0010]], t=(0x0010,0x0020,0x0030):
  - r_out = [[0,0x0010,0],[0xFFF0,0,0],[0,0,0x0010]].
  - t_out = (0xFFE0,0x0010,0xFFD0).
- Truncation: R00=0x0001, other R=0, t0=0xFFFF, t1=t2=0:
  - t_out0 = 0x0001 (product -1 >>> 4 = -1, negated).
  - t0=0x0001 instead gives t_out0 = 0x0000.
- Overflow: R00=0x7FFF, t0=0x7FFF, rest 0:
  - ovf=1.
  - t_out0 = 0x8000 with POSE_INV_SAT_EN, 0x1000 without.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with a new pose:
  - Outputs stable, in_ready=0, new pose ignored.
  - After out_ready, in_ready=1 one cycle later.
- Reset mid-MAC: assert rst at step k=4:
  - Next cycle out_valid=0, in_ready=1, t_out=0, ovf=0.
  - A fresh identity pose then completes correctly.

Source files
------------

// File: rtl/pose_inv.sv
// pose_inv: inverts a rigid camera-to-world pose [R|t] into the world-to-camera
// pose [R^T | -R^T t] using one time-shared multiply/accumulate unit.
// Elements are signed fixed point (TOTAL_BITS wide, FRAC_BITS fractional).
// Optional build macro: POSE_INV_SAT_EN -- out-of-range translation results
// saturate instead of wrapping to their low TOTAL_BITS bits.
module pose_inv #(
  parameter int TOTAL_BITS = 16,
  parameter int FRAC_BITS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [9*TOTAL_BITS-1:0]   r_in,
  input  logic [3*TOTAL_BITS-1:0]   t_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [9*TOTAL_BITS-1:0]   r_out,
  output logic [3*TOTAL_BITS-1:0]   t_out,
  output logic                      ovf
);

  localparam int W  = TOTAL_BITS;
  localparam int PW = 2 * TOTAL_BITS;
  localparam int AW = 2 * TOTAL_BITS + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [3:0]           k_q;          // MAC step 0..8
  logic [1:0]           i_q;          // output row, k/3
  logic [1:0]           j_q;          // column within row, k%3
  logic signed [AW-1:0] acc_q;
  logic [3*W-1:0]       t_q;          // latched input translation
  logic [9*W-1:0]       r_out_q;
  logic [3*W-1:0]       t_out_q;
  logic                 ovf_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  // Transpose of the incoming rotation: element (i,j) lands at (j,i).
  logic [9*W-1:0] r_tr;
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_transpose
      assign r_tr[(3*(gi%3) + gi/3)*W +: W] = r_in[gi*W +: W];
    end
  endgenerate

  // r_out_q already holds R^T, so step k reads R^T[i][j] = R[j][i] at index k.
  logic signed [W-1:0]  mul_a;
  logic signed [W-1:0]  mul_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] v_full;
  logic                 v_ovf;
  logic [W-1:0]         v_out;

  assign mul_a   = r_out_q[k_q*W +: W];
  assign mul_b   = t_q[j_q*W +: W];
  assign prod    = mul_a * mul_b;
  assign acc_sum = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
  // Arithmetic shift truncates toward -inf before the negation.
  assign shifted = acc_sum >>> FRAC_BITS;
  assign v_full  = -shifted;
  // In range exactly when every bit from the W-bit sign position up agrees.
  assign v_ovf   = !((&v_full[AW-1:W-1]) || (~|v_full[AW-1:W-1]));

`ifdef POSE_INV_SAT_EN
  // Clamp to the most positive / most negative representable element.
  always_comb begin
    v_out = v_full[W-1:0];
    if (v_ovf) begin
      v_out = v_full[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Wrap: keep the low W bits.
  always_comb begin
    v_out = v_full[W-1:0];
  end
`endif

  // Control FSM plus datapath registers; outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      t_q         <= '0;
      r_out_q     <= '0;
      t_out_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            t_q        <= t_in;
            r_out_q    <= r_tr;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MAC;
          end
        end
        MAC: begin
          if (j_q == 2'd2) begin
            // Row complete: scale, negate and store one translation element.
            t_out_q[i_q*W +: W] <= v_out;
            if (v_ovf) begin
              ovf_q <= 1'b1;
            end
            acc_q <= '0;
            j_q   <= '0;
            i_q   <= i_q + 2'd1;
          end else begin
            acc_q <= acc_sum;
            j_q   <= j_q + 2'd1;
          end
          if (k_q == 4'd8) begin
            k_q         <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        DONE: begin
          // in_ready only rises the cycle after the output handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r_out     = r_out_q;
  assign t_out     = t_out_q;
  assign ovf       = ovf_q;

endmodule
